// File: rtl/resource_pool_manager.sv
// resource_pool_manager
//   NUM_POOLS independent WIDTH-bit resource counters, each loaded with
//   INIT_VALUE on reset. Serves one CONSUME / REFILL / RELOAD / QUERY
//   request at a time, with optional periodic self-regeneration of one pool.
//
// Ports
//   clk         system clock, all state on the rising edge
//   reset       asynchronous, active-low reset
//   req_valid   request present
//   req_ready   block can accept a request (high only in IDLE)
//   req_pool    target pool index (out-of-range indices are rejected)
//   req_op      00 CONSUME, 01 REFILL, 10 RELOAD, 11 QUERY
//   req_amount  operand for CONSUME / REFILL
//   resp_valid  response present (high only in RESP)
//   resp_ready  consumer accepts the response
//   resp_ok     operation succeeded without clip or reject
//   resp_level  target pool level after the operation (0 for a bad index)
//   level_flat  all levels, pool i at [i*WIDTH +: WIDTH]
//   empty       per pool, level == 0
//   low         per pool, level < LOW_THRESH
//   dbg_state   current FSM state (0 IDLE, 1 EXEC, 2 RESP)
//
// Handshake: a transfer happens on a rising edge where valid && ready are
// both high. Once resp_valid is raised, resp_ok and resp_level hold until
// the edge on which resp_ready is seen high.
module resource_pool_manager #(
  parameter int              NUM_POOLS    = 3,
  parameter int              WIDTH        = 8,
  parameter logic [WIDTH-1:0] INIT_VALUE  = '1,
  parameter int              LOW_THRESH   = 4,
  parameter int              REGEN_PERIOD = 0,
  parameter int              REGEN_POOL   = 0,
  localparam int             PW = (NUM_POOLS > 1) ? $clog2(NUM_POOLS) : 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic [PW-1:0]              req_pool,
  input  logic [1:0]                 req_op,
  input  logic [WIDTH-1:0]           req_amount,
  output logic                       resp_valid,
  input  logic                       resp_ready,
  output logic                       resp_ok,
  output logic [WIDTH-1:0]           resp_level,
  output logic [NUM_POOLS*WIDTH-1:0] level_flat,
  output logic [NUM_POOLS-1:0]       empty,
  output logic [NUM_POOLS-1:0]       low,
  output logic [1:0]                 dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;

  localparam logic [1:0] OP_CONSUME = 2'b00;
  localparam logic [1:0] OP_REFILL  = 2'b01;
  localparam logic [1:0] OP_RELOAD  = 2'b10;

  localparam int              RCW   = (REGEN_PERIOD > 1) ? $clog2(REGEN_PERIOD) : 1;
  localparam logic [RCW-1:0]  RLAST = (REGEN_PERIOD > 0) ? RCW'(REGEN_PERIOD - 1) : '0;
  localparam logic [PW-1:0]   RPOOL = PW'(REGEN_POOL);

  state_t           state_q, state_nxt;
  logic [PW-1:0]    cap_pool;
  logic [1:0]       cap_op;
  logic [WIDTH-1:0] cap_amount;
  logic [WIDTH-1:0] levels    [NUM_POOLS];
  logic [WIDTH-1:0] level_nxt [NUM_POOLS];
  logic [RCW-1:0]   rcnt, rcnt_nxt;
  logic             pending, pending_nxt;

  // Operation result for the captured request.
  logic [WIDTH-1:0] cur_level, exec_level;
  logic [WIDTH:0]   refill_sum;
  logic             exec_ok, pool_valid;

  // Regeneration.
  logic             regen_tick, exec_hits_regen;
  logic [1:0]       regen_add;
  logic [WIDTH+1:0] regen_sum;
  logic [WIDTH-1:0] regen_level;

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_nxt;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_nxt = state_q;
    case (state_q)
      S_IDLE:  if (req_valid) state_nxt = S_EXEC;
      S_EXEC:  state_nxt = S_RESP;
      S_RESP:  if (resp_ready) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    req_ready  = (state_q == S_IDLE);
    resp_valid = (state_q == S_RESP);
    dbg_state  = state_q;
  end

  // ---------------- request capture ----------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cap_pool   <= '0;
      cap_op     <= '0;
      cap_amount <= '0;
    end else if (state_q == S_IDLE && req_valid) begin
      cap_pool   <= req_pool;
      cap_op     <= req_op;
      cap_amount <= req_amount;
    end
  end

  // ---------------- operation evaluation ----------------
  always_comb begin
    cur_level  = '0;
    pool_valid = 1'b0;
    for (int i = 0; i < NUM_POOLS; i++) begin
      if (cap_pool == PW'(i)) begin
        cur_level  = levels[i];
        pool_valid = 1'b1;
      end
    end
    // One extra bit so a refill overflow is visible instead of wrapping.
    refill_sum = {1'b0, cur_level} + {1'b0, cap_amount};
    exec_level = cur_level;
    exec_ok    = 1'b1;
    case (cap_op)
      OP_CONSUME: begin
        // All-or-nothing: an over-draw leaves the level untouched.
        if (cap_amount <= cur_level) exec_level = cur_level - cap_amount;
        else                         exec_ok    = 1'b0;
      end
      OP_REFILL: begin
        if (refill_sum[WIDTH]) begin
          exec_level = '1;
          exec_ok    = 1'b0;
        end else begin
          exec_level = refill_sum[WIDTH-1:0];
        end
      end
      OP_RELOAD: exec_level = INIT_VALUE;
      default:   exec_level = cur_level;
    endcase
    if (!pool_valid) begin
      exec_level = '0;
      exec_ok    = 1'b0;
    end
  end

  // ---------------- regeneration ----------------
  // A tick that collides with an EXEC write to the regenerating pool is
  // parked in 'pending' and applied on the following edge, so the op's
  // result is stored first and the tick is never dropped.
  always_comb begin
    regen_tick      = (REGEN_PERIOD > 0) && (rcnt == RLAST);
    rcnt_nxt        = (REGEN_PERIOD > 0 && !regen_tick) ? rcnt + RCW'(1) : '0;
    regen_add       = {1'b0, regen_tick} + {1'b0, pending};
    exec_hits_regen = (state_q == S_EXEC) && pool_valid && (cap_pool == RPOOL);
    pending_nxt     = exec_hits_regen && (regen_add != 2'd0);
    regen_sum       = {2'b00, levels[REGEN_POOL]} + {{WIDTH{1'b0}}, regen_add};
    regen_level     = (regen_sum[WIDTH+1:WIDTH] != 2'b00) ? '1 : regen_sum[WIDTH-1:0];
  end

  // ---------------- level next-state ----------------
  always_comb begin
    for (int i = 0; i < NUM_POOLS; i++) level_nxt[i] = levels[i];
    level_nxt[REGEN_POOL] = regen_level;
    // The EXEC write overrides regeneration on the same pool.
    if (state_q == S_EXEC && pool_valid) begin
      for (int i = 0; i < NUM_POOLS; i++) begin
        if (cap_pool == PW'(i)) level_nxt[i] = exec_level;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_POOLS; i++) levels[i] <= INIT_VALUE;
      rcnt    <= '0;
      pending <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_POOLS; i++) levels[i] <= level_nxt[i];
      rcnt    <= rcnt_nxt;
      pending <= pending_nxt;
    end
  end

  // ---------------- response registers ----------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      resp_ok    <= 1'b0;
      resp_level <= '0;
    end else if (state_q == S_EXEC) begin
      resp_ok    <= exec_ok;
      resp_level <= exec_level;
    end
  end

  // ---------------- status decode ----------------
  always_comb begin
    level_flat = '0;
    empty      = '0;
    low        = '0;
    for (int i = 0; i < NUM_POOLS; i++) begin
      level_flat[i*WIDTH +: WIDTH] = levels[i];
      empty[i] = (levels[i] == '0);
      low[i]   = (int'(levels[i]) < LOW_THRESH);
    end
  end

endmodule

// File: tb/tb_resource_pool_manager.sv
// Bench for resource_pool_manager. Two instances share one stimulus stream:
// u_a uses the defaults (no regeneration), u_b regenerates pool 0 every 4
// cycles. A transaction-level model predicts both every cycle.
module tb_resource_pool_manager;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic       req_valid  = 1'b0;
  logic [1:0] req_pool   = '0;
  logic [1:0] req_op     = '0;
  logic [7:0] req_amount = '0;
  logic       resp_ready = 1'b0;

  logic        a_req_ready, a_resp_valid, a_resp_ok;
  logic [7:0]  a_resp_level;
  logic [23:0] a_level_flat;
  logic [2:0]  a_empty, a_low;
  logic [1:0]  a_dbg;
  logic        b_req_ready, b_resp_valid, b_resp_ok;
  logic [7:0]  b_resp_level;
  logic [23:0] b_level_flat;
  logic [2:0]  b_empty, b_low;
  logic [1:0]  b_dbg;

  resource_pool_manager u_a (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(a_req_ready), .req_pool(req_pool),
    .req_op(req_op), .req_amount(req_amount),
    .resp_valid(a_resp_valid), .resp_ready(resp_ready), .resp_ok(a_resp_ok),
    .resp_level(a_resp_level), .level_flat(a_level_flat), .empty(a_empty),
    .low(a_low), .dbg_state(a_dbg)
  );

  resource_pool_manager #(.REGEN_PERIOD(4), .REGEN_POOL(0)) u_b (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(b_req_ready), .req_pool(req_pool),
    .req_op(req_op), .req_amount(req_amount),
    .resp_valid(b_resp_valid), .resp_ready(resp_ready), .resp_ok(b_resp_ok),
    .resp_level(b_resp_level), .level_flat(b_level_flat), .empty(b_empty),
    .low(b_low), .dbg_state(b_dbg)
  );

  // ---------------- scoreboard counters ----------------
  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  // Transaction view: a request is accepted while the block is free, its
  // effect lands one edge later, and the answer is offered until taken.
  // Regeneration adds +1 (saturating) to pool 0 on every 4th edge since
  // reset; a tick landing on the same edge as an op on pool 0 is owed and
  // added one edge later.
  int m_stage = 0;              // 0 free, 1 op lands next edge, 2 answer offered
  int m_lvl  [2][3];
  int m_cnt  [2];
  int m_owed [2];
  int m_ok   [2];
  int m_rlvl [2];
  int c_pool, c_op, c_amt;
  bit mt_tick, mt_hit;
  int mt_add, mt_cur, mt_per;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_stage = 0;
      for (int k = 0; k < 2; k++) begin
        for (int i = 0; i < 3; i++) m_lvl[k][i] = 255;
        m_cnt[k] = 0; m_owed[k] = 0; m_ok[k] = 0; m_rlvl[k] = 0;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        mt_per  = (k == 0) ? 0 : 4;
        mt_tick = (mt_per > 0) && (m_cnt[k] == mt_per - 1);
        if (mt_per > 0) m_cnt[k] = (m_cnt[k] + 1) % mt_per;
        mt_hit = 1'b0;
        if (m_stage == 1) begin
          if (c_pool >= 3) begin
            m_ok[k] = 0; m_rlvl[k] = 0;
          end else begin
            mt_cur = m_lvl[k][c_pool];
            m_ok[k] = 1;
            case (c_op)
              0: if (c_amt <= mt_cur) mt_cur = mt_cur - c_amt; else m_ok[k] = 0;
              1: if (mt_cur + c_amt > 255) begin mt_cur = 255; m_ok[k] = 0; end
                 else mt_cur = mt_cur + c_amt;
              2: mt_cur = 255;
              default: ;
            endcase
            m_lvl[k][c_pool] = mt_cur;
            m_rlvl[k] = mt_cur;
            mt_hit = (c_pool == 0);
          end
        end
        mt_add = (mt_tick ? 1 : 0) + m_owed[k];
        if (mt_hit) m_owed[k] = mt_add;
        else begin
          m_lvl[k][0] = (m_lvl[k][0] + mt_add > 255) ? 255 : m_lvl[k][0] + mt_add;
          m_owed[k] = 0;
        end
      end
      if (m_stage == 0 && req_valid) begin
        c_pool = req_pool; c_op = req_op; c_amt = req_amount;
        m_stage = 1;
      end else if (m_stage == 1) m_stage = 2;
      else if (m_stage == 2 && resp_ready) m_stage = 0;
    end
  end

  function automatic logic [23:0] exp_flat(input int k);
    logic [23:0] f;
    for (int i = 0; i < 3; i++) f[i*8 +: 8] = 8'(m_lvl[k][i]);
    return f;
  endfunction

  function automatic logic [2:0] exp_empty(input int k);
    logic [2:0] e;
    for (int i = 0; i < 3; i++) e[i] = (m_lvl[k][i] == 0);
    return e;
  endfunction

  function automatic logic [2:0] exp_low(input int k);
    logic [2:0] l;
    for (int i = 0; i < 3; i++) l[i] = (m_lvl[k][i] < 4);
    return l;
  endfunction

  task automatic cmp(input string n, input int k, input logic rr, input logic rv,
                     input logic ok, input logic [7:0] lv, input logic [23:0] fl,
                     input logic [2:0] em, input logic [2:0] lo);
    chk({n, ".req_ready"}, 32'(rr), 32'(m_stage == 0));
    chk({n, ".resp_valid"}, 32'(rv), 32'(m_stage == 2));
    if (m_stage == 2) begin
      chk({n, ".resp_ok"}, 32'(ok), 32'(m_ok[k]));
      chk({n, ".resp_level"}, 32'(lv), 32'(m_rlvl[k]));
    end
    chk({n, ".level_flat"}, 32'(fl), 32'(exp_flat(k)));
    chk({n, ".empty"}, 32'(em), 32'(exp_empty(k)));
    chk({n, ".low"}, 32'(lo), 32'(exp_low(k)));
  endtask

  // One compare process, on the falling edge, away from the active edge.
  always @(negedge clk) begin
    cmp("a", 0, a_req_ready, a_resp_valid, a_resp_ok, a_resp_level, a_level_flat, a_empty, a_low);
    cmp("b", 1, b_req_ready, b_resp_valid, b_resp_ok, b_resp_level, b_level_flat, b_empty, b_low);
  end

  // ---------------- driver ----------------
  // Issues one request (inputs change 1 time unit after a rising edge),
  // optionally aligned so the op lands on u_b's regeneration tick, holds
  // the response for 'stall' cycles, then accepts it. Returns u_a's answer.
  task automatic do_req(input int pool, input int op, input int amt, input int stall,
                        input bit align, output logic ok, output logic [7:0] lvl);
    int n;
    n = 0;
    while (!a_req_ready && n < 20) begin @(posedge clk); #1; n++; end
    chk("req_ready_wait", 32'(a_req_ready), 32'd1);
    if (align) begin
      // Accepting while the tick counter reads 2 puts the op's edge on the tick.
      n = 0;
      while (m_cnt[1] != 2 && n < 10) begin @(posedge clk); #1; n++; end
    end
    req_valid  = 1'b1;
    req_pool   = pool[1:0];
    req_op     = op[1:0];
    req_amount = amt[7:0];
    @(posedge clk); #1;
    req_valid = 1'b0;
    n = 0;
    while (!a_resp_valid && n < 10) begin @(posedge clk); #1; n++; end
    chk("resp_latency", 32'(n), 32'd1);
    ok  = a_resp_ok;
    lvl = a_resp_level;
    repeat (stall) begin @(posedge clk); #1; end
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
  endtask

  // ---------------- directed tests ----------------
  logic       r_ok;
  logic [7:0] r_lvl;

  initial begin
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;

    // 1: reset state
    chk("t1_flat_a", 32'(a_level_flat), 32'hFFFFFF);
    chk("t1_flat_b", 32'(b_level_flat), 32'hFFFFFF);
    chk("t1_empty", 32'(a_empty), 32'd0);
    chk("t1_low", 32'(a_low), 32'd0);
    chk("t1_req_ready", 32'(a_req_ready), 32'd1);
    chk("t1_resp_valid", 32'(a_resp_valid), 32'd0);
    chk("t1_resp_ok", 32'(a_resp_ok), 32'd0);
    chk("t1_resp_level", 32'(a_resp_level), 32'd0);

    // 2: consume then rejected over-draw
    do_req(1, 0, 200, 0, 1'b0, r_ok, r_lvl);
    chk("t2_ok1", 32'(r_ok), 32'd1);
    chk("t2_lvl1", 32'(r_lvl), 32'd55);
    do_req(1, 0, 60, 0, 1'b0, r_ok, r_lvl);
    chk("t2_ok2", 32'(r_ok), 32'd0);
    chk("t2_lvl2", 32'(r_lvl), 32'd55);

    // 3: near-empty, clipped refill, reload
    do_req(2, 0, 253, 0, 1'b0, r_ok, r_lvl);
    chk("t3_ok1", 32'(r_ok), 32'd1);
    chk("t3_lvl1", 32'(r_lvl), 32'd2);
    chk("t3_low", 32'(a_low), 32'b100);
    do_req(2, 1, 255, 0, 1'b0, r_ok, r_lvl);
    chk("t3_ok2", 32'(r_ok), 32'd0);
    chk("t3_lvl2", 32'(r_lvl), 32'd255);
    do_req(2, 2, 0, 0, 1'b0, r_ok, r_lvl);
    chk("t3_ok3", 32'(r_ok), 32'd1);
    chk("t3_lvl3", 32'(r_lvl), 32'd255);

    // 4: drain pool 0 under 10 cycles of back-pressure
    do_req(0, 0, 255, 10, 1'b0, r_ok, r_lvl);
    chk("t4_ok", 32'(r_ok), 32'd1);
    chk("t4_lvl", 32'(r_lvl), 32'd0);
    chk("t4_resp_level_held", 32'(a_resp_level), 32'd0);
    chk("t4_empty", 32'(a_empty), 32'b001);
    chk("t4_low", 32'(a_low), 32'b001);
    chk("t4_flat_a", 32'(a_level_flat), 32'hFF3700);

    // 5: let u_b regenerate, then land a consume on a tick edge
    repeat (12) @(posedge clk);
    #1;
    do_req(0, 0, 1, 0, 1'b1, r_ok, r_lvl);
    chk("t5_a_ok", 32'(r_ok), 32'd0);
    chk("t5_a_lvl", 32'(r_lvl), 32'd0);
    repeat (10) @(posedge clk);
    #1;

    // 6a: reset while the op is in flight
    req_valid = 1'b1; req_pool = 2'd1; req_op = 2'd0; req_amount = 8'd5;
    @(posedge clk); #1;
    req_valid = 1'b0;
    #2 reset = 1'b0;
    #1;
    chk("t6_exec_resp_valid", 32'(a_resp_valid), 32'd0);
    chk("t6_exec_req_ready", 32'(a_req_ready), 32'd1);
    chk("t6_exec_flat", 32'(a_level_flat), 32'hFFFFFF);
    @(posedge clk); #1 reset = 1'b1;

    // 6b: reset while the response is being offered
    req_valid = 1'b1; req_pool = 2'd0; req_op = 2'd0; req_amount = 8'd10;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    chk("t6_resp_seen", 32'(a_resp_valid), 32'd1);
    #2 reset = 1'b0;
    #1;
    chk("t6_resp_resp_valid", 32'(a_resp_valid), 32'd0);
    chk("t6_resp_ok", 32'(a_resp_ok), 32'd0);
    chk("t6_resp_level", 32'(a_resp_level), 32'd0);
    chk("t6_resp_flat", 32'(a_level_flat), 32'hFFFFFF);
    @(posedge clk); #1 reset = 1'b1;

    // 6c: out-of-range pool index
    do_req(1, 0, 100, 0, 1'b0, r_ok, r_lvl);
    chk("t6_prep_lvl", 32'(r_lvl), 32'd155);
    do_req(3, 0, 1, 0, 1'b0, r_ok, r_lvl);
    chk("t6_bad_ok", 32'(r_ok), 32'd0);
    chk("t6_bad_lvl", 32'(r_lvl), 32'd0);
    do_req(3, 2, 0, 0, 1'b0, r_ok, r_lvl);
    chk("t6_bad_reload_ok", 32'(r_ok), 32'd0);
    chk("t6_bad_flat", 32'(a_level_flat), 32'hFF9BFF);

    repeat (5) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish, %0d/%0d so far", n_pass, n_total);
    $fatal(1, "watchdog expired");
  end

endmodule
